apb_mem_window_bridge: RTL and testbench
========================================

// Module: apb_mem_window_bridge
// PURPOSE
//   APB slave that maps NUM_MEM SRAM tables into APB windows. Each table is MEM_DW bits wide and
//   DEPTH entries deep; each entry spans WPE=ceil(MEM_DW/32) 32-bit APB words.
//   Writes go into a per-window staging register and commit on the last word.
//   Reads fetch the whole entry into a per-window hold register, so other words of that entry hit
//   the hold register with zero memory traffic. The block sits behind the APB decoder, next to the
//   register blocks, and drives the memory ports of the table wrappers.
// PARAMETERS
//   NUM_MEM     2       number of memory windows (1..8)
//   MEM_DW      63      memory entry width in bits (1..256)
//   DEPTH       20      entries per memory
//   MEM_AW      5       memory address width, >= clog2(DEPTH)
//   WIN_BASE    'h0     byte address of window 0
//   WIN_STRIDE  'h100   byte distance between windows; must be >= DEPTH<<ESH
//   MEM_RD_LAT  1       memory read latency in cycles (1..4)
// PORTS
//   clk        in   1               clock
//   rst        in   1               synchronous active-high reset
//   psel       in   1               APB select
//   penable    in   1               APB enable
//   pwrite     in   1               APB write
//   paddr      in   32              APB byte address
//   pwdata     in   32              APB write data
//   prdata     out  32              APB read data
//   pready     out  1               APB ready
//   pslverr    out  1               APB error
//   mem_en     out  NUM_MEM         per-memory access strobe
//   mem_we     out  NUM_MEM         per-memory write strobe (only with mem_en)
//   mem_addr   out  MEM_AW          shared entry address
//   mem_wdata  out  MEM_DW          shared write data
//   mem_rdata  in   NUM_MEM*MEM_DW  read data; memory i is slice [i*MEM_DW +: MEM_DW]
// BEHAVIOUR
//   Address decode
//   - ESH = clog2(WPE)+2.
//   - Window i covers [WIN_BASE+i*WIN_STRIDE, +DEPTH<<ESH).
//   - entry = off>>ESH. word = off[ESH-1:2].
//   Access and errors
//   - An access starts on the cycle T where psel&penable is seen in state IDLE.
//   - Error cases: paddr[1:0]!=0, no window hit, or word>=WPE.
//     - Response: pslverr=1, prdata=32'hBADD_C0DE, no mem_en.
//   - pready/pslverr/prdata are registered. They are valid for exactly one cycle, then the FSM
//     returns to IDLE.
//   FSM states: IDLE, RESP, WR_COMMIT, RD_ISSUE, RD_WAIT
//   - Error, read hit, or write to a non-final word: IDLE->RESP, pready at T+1.
//   - Write to word k: staging[i] word k <= pwdata. The final word keeps only its low
//     MEM_DW-32*(WPE-1) bits; upper bits are dropped.
//   - Write to the final word: IDLE->WR_COMMIT at T+1.
//     - mem_en[i]=mem_we[i]=1, mem_addr=entry, mem_wdata=staging[i] (with the word just written).
//     - pready=1 in the same cycle.
//     - If hold[i] is valid for this entry, it is invalidated.
//   - Read hit = hold_vld[i] and hold_addr[i]==entry.
//     - prdata = hold word, zero-extended.
//   - Read miss: IDLE->RD_ISSUE at T+1 with mem_en[i]=1, mem_we=0.
//     - RD_WAIT for MEM_RD_LAT cycles; capture mem_rdata slice at T+1+MEM_RD_LAT.
//     - Set hold[i]/hold_addr[i]/hold_vld[i] on capture.
//     - RESP at T+2+MEM_RD_LAT with prdata = word of the captured data.
//   - A write to a non-final word never invalidates hold. Hold reflects committed memory only.
//   - Staging is not cleared after a commit. A partial rewrite reuses the prior words.
//   - While not IDLE, APB inputs are ignored. Only one access is outstanding.
//   - mem_en is one-hot or zero. mem_addr and mem_wdata are 0 when mem_en==0.
//   Reset
//   - FSM=IDLE; pready=0, pslverr=0, prdata=0; mem_en=0, mem_we=0.
//   - Hold valid bits cleared; staging=0.
//   - rst in any state aborts it. In the next cycle no strobe or pready is driven and any
//     in-flight read data is discarded.
// TESTING (defaults; window0 0x000-0x09F, window1 0x100-0x19F, 8B/entry)
//   1 W 0x10=DEADBEEF, W 0x14=FFFFFFFF
//     -> first write: pready at T+1, no mem_en.
//     -> second write: mem_en[0]=mem_we[0]=1, addr 2, wdata 63'h7FFFFFFF_DEADBEEF.
//   2 R 0x114, mem returns 63'h12345678_9ABCDEF0
//     -> mem_en[1] at T+1, pready at T+3, prdata 12345678.
//     -> then R 0x110: pready at T+1, no mem_en, prdata 9ABCDEF0.
//   3 After test 2, W 0x110, W 0x114, R 0x110
//     -> hold invalidated, fresh memory read issued, new data returned.
//   4 R 0x0A0 (entry 20), R 0x200, W 0x011
//     -> each: pslverr=1 at T+1, prdata BADDC0DE, mem_en never asserted.
//   5 rst during RD_WAIT
//     -> next cycle pready=0, mem_en=0.
//     -> re-read of the same entry misses and issues mem_en.
//   6 MEM_RD_LAT=3, NUM_MEM=4, MEM_DW=100 (WPE=4, ESH=4)
//     -> R word3 of window3 entry0: pready at T+5, prdata[3:0] = data[99:96], upper bits 0.

Source files
------------

// File: rtl/apb_mem_window_bridge.sv
// apb_mem_window_bridge
//   APB slave that exposes NUM_MEM SRAM tables as APB address windows. Each
//   table entry is MEM_DW bits and occupies WPE 32-bit APB words. Writes fill
//   a per-window staging register and commit to memory on the final word of
//   the entry. Reads pull a whole entry into a per-window hold register, so
//   later reads of other words of that entry are served without memory traffic.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   psel/penable/pwrite      APB control
//   paddr, pwdata            APB byte address and write data
//   prdata, pready, pslverr  registered APB response (one-cycle pulse)
//   mem_en, mem_we           per-memory strobes (one-hot or zero)
//   mem_addr, mem_wdata      shared entry address / write data (0 when idle)
//   mem_rdata                packed read data, memory i at [i*MEM_DW +: MEM_DW]
module apb_mem_window_bridge #(
  parameter int          NUM_MEM    = 2,
  parameter int          MEM_DW     = 63,
  parameter int          DEPTH      = 20,
  parameter int          MEM_AW     = 5,
  parameter logic [31:0] WIN_BASE   = 32'h0,
  parameter logic [31:0] WIN_STRIDE = 32'h100,
  parameter int          MEM_RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [31:0]               paddr,
  input  logic [31:0]               pwdata,
  output logic [31:0]               prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic [NUM_MEM-1:0]        mem_en,
  output logic [NUM_MEM-1:0]        mem_we,
  output logic [MEM_AW-1:0]         mem_addr,
  output logic [MEM_DW-1:0]         mem_wdata,
  input  logic [NUM_MEM*MEM_DW-1:0] mem_rdata
);

  localparam int WPE = (MEM_DW + 31) / 32;
  localparam int ESH = $clog2(WPE) + 2;
  localparam int WORDW = (ESH > 2) ? ESH - 2 : 1;
  localparam int WINW = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
  localparam logic [31:0] WIN_SPAN = 32'(DEPTH) << ESH;

  typedef enum logic [2:0] {IDLE, RESP, WR_COMMIT, RD_ISSUE, RD_WAIT} stateT;

  stateT state;
  logic [1:0] waitCnt;

  logic [WPE*32-1:0] staging [NUM_MEM];
  logic [MEM_DW-1:0] hold [NUM_MEM];
  logic [MEM_AW-1:0] holdAddr [NUM_MEM];
  logic [NUM_MEM-1:0] holdVld;

  logic [WINW-1:0] reqWin;
  logic [MEM_AW-1:0] reqEntry;
  logic [WORDW-1:0] reqWord;

  logic decHit;
  logic decErr;
  logic [WINW-1:0] decWin;
  logic [31:0] decOff;
  logic [MEM_AW-1:0] decEntry;
  logic [WORDW-1:0] decWord;
  logic decLast;
  logic decHoldHit;
  logic [WPE*32-1:0] stageNext;
  logic [WPE*32-1:0] holdPad;
  logic [31:0] holdWord;
  logic [MEM_DW-1:0] capData;
  logic [WPE*32-1:0] capPad;
  logic [31:0] capWord;

  // Window decode of the current APB address. Windows never overlap, so at
  // most one iteration matches. With a single word per entry there are no
  // word-select bits and the word index is forced to zero.
  always_comb begin
    decHit = 1'b0;
    decWin = '0;
    decOff = '0;
    for (int i = 0; i < NUM_MEM; i++) begin
      if (paddr >= WIN_BASE + 32'(i) * WIN_STRIDE &&
          paddr < WIN_BASE + 32'(i) * WIN_STRIDE + WIN_SPAN) begin
        decHit = 1'b1;
        decWin = WINW'(i);
        decOff = paddr - (WIN_BASE + 32'(i) * WIN_STRIDE);
      end
    end
    decEntry = MEM_AW'(decOff >> ESH);
    decWord = (ESH > 2) ? WORDW'(decOff >> 2) : '0;
    decLast = (32'(decWord) == 32'(WPE - 1));
    decErr = (paddr[1:0] != 2'b00) || !decHit || (32'(decWord) >= 32'(WPE));
    decHoldHit = holdVld[decWin] && (holdAddr[decWin] == decEntry);
  end

  // Staging image with the incoming word merged in; this is both the next
  // staging value and, on the final word, the data committed to memory.
  // Bits of the final word above MEM_DW fall off when it is truncated.
  always_comb begin
    stageNext = staging[decWin];
    stageNext[decWord*32 +: 32] = pwdata;
  end

  // Word selection for read hits (from hold) and read misses (from the
  // memory slice being captured), zero-extended to the full word grid.
  always_comb begin
    holdPad = '0;
    holdPad[MEM_DW-1:0] = hold[decWin];
    holdWord = holdPad[decWord*32 +: 32];
    capData = mem_rdata[reqWin*MEM_DW +: MEM_DW];
    capPad = '0;
    capPad[MEM_DW-1:0] = capData;
    capWord = capPad[reqWord*32 +: 32];
  end

  // Access FSM. All outputs are registered and default to zero every cycle,
  // so each response and memory strobe is a single-cycle pulse and reset in
  // any state drops them in the following cycle and discards in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      waitCnt <= '0;
      pready <= 1'b0;
      pslverr <= 1'b0;
      prdata <= '0;
      mem_en <= '0;
      mem_we <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      holdVld <= '0;
      reqWin <= '0;
      reqEntry <= '0;
      reqWord <= '0;
      for (int i = 0; i < NUM_MEM; i++) begin
        staging[i] <= '0;
        hold[i] <= '0;
        holdAddr[i] <= '0;
      end
    end else begin
      pready <= 1'b0;
      pslverr <= 1'b0;
      prdata <= '0;
      mem_en <= '0;
      mem_we <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      case (state)
        IDLE: begin
          if (psel && penable) begin
            reqWin <= decWin;
            reqEntry <= decEntry;
            reqWord <= decWord;
            if (decErr) begin
              pready <= 1'b1;
              pslverr <= 1'b1;
              prdata <= 32'hBADD_C0DE;
              state <= RESP;
            end else if (pwrite) begin
              staging[decWin] <= stageNext;
              pready <= 1'b1;
              if (decLast) begin
                mem_en <= NUM_MEM'(1) << decWin;
                mem_we <= NUM_MEM'(1) << decWin;
                mem_addr <= decEntry;
                mem_wdata <= stageNext[MEM_DW-1:0];
                // Hold mirrors committed memory, so drop it if overwritten.
                if (decHoldHit) holdVld[decWin] <= 1'b0;
                state <= WR_COMMIT;
              end else begin
                state <= RESP;
              end
            end else if (decHoldHit) begin
              pready <= 1'b1;
              prdata <= holdWord;
              state <= RESP;
            end else begin
              mem_en <= NUM_MEM'(1) << decWin;
              mem_addr <= decEntry;
              state <= RD_ISSUE;
            end
          end
        end
        RESP, WR_COMMIT: state <= IDLE;
        RD_ISSUE: begin
          waitCnt <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (waitCnt == 2'(MEM_RD_LAT - 1)) begin
            hold[reqWin] <= capData;
            holdAddr[reqWin] <= reqEntry;
            holdVld[reqWin] <= 1'b1;
            pready <= 1'b1;
            prdata <= capWord;
            state <= RESP;
          end else begin
            waitCnt <= waitCnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_window_bridge.sv
// tb_apb_mem_window_bridge
//   Self-checking bench for apb_mem_window_bridge. A default instance talks to
//   two behavioural 1-cycle memories; a second wide instance (4 windows,
//   100-bit entries, 3-cycle latency) talks to a pipelined memory model.
//   Expected responses are queued as stimulus is issued and popped when the
//   DUT answers.
module tb_apb_mem_window_bridge;

  typedef struct packed {
    logic [31:0] prdata;
    logic        err;
    logic [7:0]  lat;
    logic [7:0]  acc;
  } respT;

  localparam logic [99:0] WIDE_DATA = 100'hA_1234_5678_9ABC_DEF0_1357_9BDF;

  logic clk = 1'b0;
  logic rst;
  logic psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic pready, pslverr;
  logic [1:0] memEn, memWe;
  logic [4:0] memAddr;
  logic [62:0] memWdata;
  logic [125:0] memRdata;

  logic pselW, penableW, pwriteW;
  logic [31:0] paddrW, pwdataW, prdataW;
  logic preadyW, pslverrW;
  logic [3:0] memEnW, memWeW;
  logic [4:0] memAddrW;
  logic [99:0] memWdataW;
  logic [399:0] memRdataW;

  logic [62:0] memArr0 [20];
  logic [62:0] memArr1 [20];
  logic [62:0] rd0, rd1;
  logic [99:0] wideP1, wideP2, wideP3;

  respT sbq[$];
  int checks = 0;
  int failures = 0;
  logic [1:0] lastEn, lastWe;
  logic [4:0] lastAddr;
  logic [62:0] lastWdata;

  always #5 clk = ~clk;

  apb_mem_window_bridge dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr),
    .mem_wdata(memWdata), .mem_rdata(memRdata)
  );

  apb_mem_window_bridge #(
    .NUM_MEM(4), .MEM_DW(100), .DEPTH(20), .MEM_AW(5),
    .WIN_BASE(32'h0), .WIN_STRIDE(32'h200), .MEM_RD_LAT(3)
  ) dutWide (
    .clk(clk), .rst(rst), .psel(pselW), .penable(penableW), .pwrite(pwriteW),
    .paddr(paddrW), .pwdata(pwdataW), .prdata(prdataW), .pready(preadyW),
    .pslverr(pslverrW), .mem_en(memEnW), .mem_we(memWeW), .mem_addr(memAddrW),
    .mem_wdata(memWdataW), .mem_rdata(memRdataW)
  );

  // Single-cycle synchronous memories behind the default instance.
  always @(posedge clk) begin
    if (memEn[0]) begin
      if (memWe[0]) memArr0[memAddr] <= memWdata;
      else rd0 <= memArr0[memAddr];
    end
    if (memEn[1]) begin
      if (memWe[1]) memArr1[memAddr] <= memWdata;
      else rd1 <= memArr1[memAddr];
    end
  end
  assign memRdata = {rd1, rd0};

  // Three-stage read pipeline for memory 3 of the wide instance; holds
  // WIDE_DATA at entry 0, zero elsewhere, and zero when not being read.
  always @(posedge clk) begin
    wideP1 <= (memEnW[3] && !memWeW[3] && memAddrW == 5'd0) ? WIDE_DATA : 100'h0;
    wideP2 <= wideP1;
    wideP3 <= wideP2;
  end
  assign memRdataW = {wideP3, 300'h0};

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // One APB transfer on the default instance; returns response, latency in
  // cycles after the enable cycle, and number of cycles with a memory strobe.
  task automatic apbXfer(input logic [31:0] addr, input logic wr,
                         input logic [31:0] data, output respT r);
    int lat;
    int acc;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0; acc = 0; r = '0;
    lastEn = '0; lastWe = '0; lastAddr = '0; lastWdata = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (memEn != 2'b00) begin
        acc++;
        lastEn = memEn; lastWe = memWe; lastAddr = memAddr; lastWdata = memWdata;
      end
      if (pready) begin
        lat = c;
        r.prdata = prdata;
        r.err = pslverr;
        break;
      end
    end
    if (lat == 0) begin
      checks++; failures++;
      $display("[TB] FAIL timeout addr=%h no pready within 20 cycles", addr);
    end
    r.lat = 8'(lat);
    r.acc = 8'(acc);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // Same transfer on the wide instance.
  task automatic apbXferW(input logic [31:0] addr, output respT r);
    int lat;
    int acc;
    pselW = 1'b1; penableW = 1'b0; pwriteW = 1'b0; paddrW = addr; pwdataW = '0;
    @(posedge clk); #1;
    penableW = 1'b1;
    lat = 0; acc = 0; r = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (memEnW != 4'b0000) acc++;
      if (preadyW) begin
        lat = c;
        r.prdata = prdataW;
        r.err = pslverrW;
        break;
      end
    end
    if (lat == 0) begin
      checks++; failures++;
      $display("[TB] FAIL timeout_wide addr=%h no pready within 20 cycles", addr);
    end
    r.lat = 8'(lat);
    r.acc = 8'(acc);
    @(posedge clk); #1;
    pselW = 1'b0; penableW = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({pready, pslverr, prdata, memEn, memWe, memAddr, memWdata} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got %b %b %h %b %b %h %h exp all zero",
               pready, pslverr, prdata, memEn, memWe, memAddr, memWdata);
    end
    checks++;
    if ({preadyW, pslverrW, prdataW, memEnW, memWeW, memAddrW, memWdataW} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs_wide got %b %b %h %b %b %h %h exp all zero",
               preadyW, pslverrW, prdataW, memEnW, memWeW, memAddrW, memWdataW);
    end
  endtask

  task automatic test_write_commit;
    respT r, e;
    sbq.push_back({32'h0, 1'b0, 8'd1, 8'd0});
    apbXfer(32'h10, 1'b1, 32'hDEADBEEF, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL wr_word0 got %h exp %h", r, e); end
    sbq.push_back({32'h0, 1'b0, 8'd1, 8'd1});
    apbXfer(32'h14, 1'b1, 32'hFFFFFFFF, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL wr_final got %h exp %h", r, e); end
    checks++;
    if ({lastEn, lastWe, lastAddr, lastWdata} !== {2'b01, 2'b01, 5'd2, 63'h7FFFFFFF_DEADBEEF}) begin
      failures++;
      $display("[TB] FAIL wr_final_mem got en=%b we=%b addr=%0d wdata=%h exp en=01 we=01 addr=2 wdata=7fffffffdeadbeef",
               lastEn, lastWe, lastAddr, lastWdata);
    end
  endtask

  task automatic test_read_miss_hit;
    respT r, e;
    // Populate window1 entry 2 through the bridge itself.
    sbq.push_back({32'h0, 1'b0, 8'd1, 8'd0});
    apbXfer(32'h110, 1'b1, 32'h9ABCDEF0, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL w1_wr0 got %h exp %h", r, e); end
    sbq.push_back({32'h0, 1'b0, 8'd1, 8'd1});
    apbXfer(32'h114, 1'b1, 32'h12345678, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL w1_wr1 got %h exp %h", r, e); end
    sbq.push_back({32'h12345678, 1'b0, 8'd3, 8'd1});
    apbXfer(32'h114, 1'b0, 32'h0, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL rd_miss got %h exp %h", r, e); end
    checks++;
    if ({lastEn, lastWe, lastAddr} !== {2'b10, 2'b00, 5'd2}) begin
      failures++;
      $display("[TB] FAIL rd_miss_mem got en=%b we=%b addr=%0d exp en=10 we=00 addr=2",
               lastEn, lastWe, lastAddr);
    end
    sbq.push_back({32'h9ABCDEF0, 1'b0, 8'd1, 8'd0});
    apbXfer(32'h110, 1'b0, 32'h0, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL rd_hit got %h exp %h", r, e); end
  endtask

  task automatic test_hold_invalidate;
    respT r, e;
    logic [31:0] addrs [6];
    logic wrs [6];
    logic [31:0] datas [6];
    addrs[0] = 32'h110; wrs[0] = 1'b1; datas[0] = 32'hA5A5A5A5;
    sbq.push_back({32'h0, 1'b0, 8'd1, 8'd0});
    addrs[1] = 32'h114; wrs[1] = 1'b1; datas[1] = 32'h0F0F0F0F;
    sbq.push_back({32'h0, 1'b0, 8'd1, 8'd1});
    addrs[2] = 32'h110; wrs[2] = 1'b0; datas[2] = 32'h0;
    sbq.push_back({32'hA5A5A5A5, 1'b0, 8'd3, 8'd1});
    addrs[3] = 32'h110; wrs[3] = 1'b1; datas[3] = 32'h55555555;
    sbq.push_back({32'h0, 1'b0, 8'd1, 8'd0});
    addrs[4] = 32'h114; wrs[4] = 1'b0; datas[4] = 32'h0;
    sbq.push_back({32'h0F0F0F0F, 1'b0, 8'd1, 8'd0});
    addrs[5] = 32'h110; wrs[5] = 1'b0; datas[5] = 32'h0;
    sbq.push_back({32'hA5A5A5A5, 1'b0, 8'd1, 8'd0});
    for (int i = 0; i < 6; i++) begin
      apbXfer(addrs[i], wrs[i], datas[i], r);
      e = sbq.pop_front();
      checks++;
      if (r !== e) begin
        failures++;
        $display("[TB] FAIL hold_inv step%0d addr=%h got %h exp %h", i, addrs[i], r, e);
      end
    end
  endtask

  task automatic test_staging_reuse;
    respT r, e;
    sbq.push_back({32'h0, 1'b0, 8'd1, 8'd1});
    apbXfer(32'h0C, 1'b1, 32'h11111111, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL stage_wr got %h exp %h", r, e); end
    checks++;
    if ({lastEn, lastWe, lastAddr, lastWdata} !== {2'b01, 2'b01, 5'd1, 63'h11111111_DEADBEEF}) begin
      failures++;
      $display("[TB] FAIL stage_mem got en=%b we=%b addr=%0d wdata=%h exp en=01 we=01 addr=1 wdata=11111111deadbeef",
               lastEn, lastWe, lastAddr, lastWdata);
    end
    sbq.push_back({32'hDEADBEEF, 1'b0, 8'd3, 8'd1});
    apbXfer(32'h08, 1'b0, 32'h0, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL stage_rd0 got %h exp %h", r, e); end
    sbq.push_back({32'h11111111, 1'b0, 8'd1, 8'd0});
    apbXfer(32'h0C, 1'b0, 32'h0, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL stage_rd1 got %h exp %h", r, e); end
  endtask

  task automatic test_errors;
    respT r, e;
    logic [31:0] addrs [4];
    logic wrs [4];
    addrs[0] = 32'h0A0; wrs[0] = 1'b0;
    addrs[1] = 32'h200; wrs[1] = 1'b0;
    addrs[2] = 32'h011; wrs[2] = 1'b1;
    addrs[3] = 32'h1A0; wrs[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sbq.push_back({32'hBADDC0DE, 1'b1, 8'd1, 8'd0});
      apbXfer(addrs[i], wrs[i], 32'hCAFEF00D, r);
      e = sbq.pop_front();
      checks++;
      if (r !== e) begin
        failures++;
        $display("[TB] FAIL err addr=%h got %h exp %h", addrs[i], r, e);
      end
    end
  endtask

  task automatic test_reset_abort;
    respT r, e;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10; pwdata = '0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (memEn !== 2'b01) begin
      failures++;
      $display("[TB] FAIL abort_issue mem_en got %b exp 01", memEn);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({pready, memEn, memWe} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL abort_quiet got pready=%b mem_en=%b mem_we=%b exp 0 00 00",
               pready, memEn, memWe);
    end
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    // Hold was cleared, so the previously held entry misses again.
    sbq.push_back({32'h11111111, 1'b0, 8'd3, 8'd1});
    apbXfer(32'h0C, 1'b0, 32'h0, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL abort_hold_clr got %h exp %h", r, e); end
    sbq.push_back({32'hDEADBEEF, 1'b0, 8'd3, 8'd1});
    apbXfer(32'h10, 1'b0, 32'h0, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL abort_reread got %h exp %h", r, e); end
    // Staging was cleared, so a lone final-word write commits zero low word.
    sbq.push_back({32'h0, 1'b0, 8'd1, 8'd1});
    apbXfer(32'h14, 1'b1, 32'h00000001, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL abort_wr got %h exp %h", r, e); end
    checks++;
    if (lastWdata !== 63'h00000001_00000000) begin
      failures++;
      $display("[TB] FAIL abort_stage_clr wdata got %h exp 0000000100000000", lastWdata);
    end
    sbq.push_back({32'h00000001, 1'b0, 8'd3, 8'd1});
    apbXfer(32'h14, 1'b0, 32'h0, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL abort_rd_new got %h exp %h", r, e); end
  endtask

  task automatic test_wide;
    respT r, e;
    sbq.push_back({32'h0000000A, 1'b0, 8'd5, 8'd1});
    apbXferW(32'h60C, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL wide_miss got %h exp %h", r, e); end
    sbq.push_back({32'h13579BDF, 1'b0, 8'd1, 8'd0});
    apbXferW(32'h600, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL wide_hit0 got %h exp %h", r, e); end
    sbq.push_back({32'h9ABCDEF0, 1'b0, 8'd1, 8'd0});
    apbXferW(32'h604, r);
    e = sbq.pop_front();
    checks++;
    if (r !== e) begin failures++; $display("[TB] FAIL wide_hit1 got %h exp %h", r, e); end
  endtask

  initial begin
    rst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    pselW = 1'b0; penableW = 1'b0; pwriteW = 1'b0; paddrW = '0; pwdataW = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_write_commit();
    test_read_miss_hit();
    test_hold_invalidate();
    test_staging_reuse();
    test_errors();
    test_reset_abort();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
